// File: rtl/lc4_mem_pkg.sv
// Shared data-memory types and default geometry for the LC4 memory system.
// Used by lc4_memory, lc4_processor and the d-side arbiter.
package lc4_mem_pkg;

  localparam int WORD_SIZE_DEF = 256;
  localparam int ADDR_BITS_DEF = 3;

  typedef enum logic {
    ARB_PROC_PRI    = 1'b0,
    ARB_HOST_FORCED = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_PROC = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/lc4_arb_wait_ctr.sv
// Saturating host wait counter, advanced only on gwe cycles.
// expired flags that the count being loaded this cycle reaches MAX_WAIT.
module lc4_arb_wait_ctr #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (clr) begin
        count_d = '0;
      end else if (inc && (count_q != MAX_C)) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  assign expired = (count_d == MAX_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lc4_dmem_arbiter.sv
// Shares the data-memory port between the processor (priority) and a host
// agent; a bounded wait forces one host access after MAX_WAIT denials.
module lc4_dmem_arbiter
  import lc4_mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 p_req,
  input  logic                 p_we,
  input  logic [ADDR_BITS-1:0] p_addr,
  input  logic [WORD_SIZE-1:0] p_wdata,
  output logic                 p_gnt,
  output logic                 p_stall,
  output logic                 p_rvalid,
  output logic [WORD_SIZE-1:0] p_rdata,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [ADDR_BITS-1:0] h_addr,
  input  logic [WORD_SIZE-1:0] h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [WORD_SIZE-1:0] h_rdata,
  output logic [ADDR_BITS-1:0] mem_raddr,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("lc4_dmem_arbiter: MAX_WAIT must be within 1..15");
  end

  arb_state_e state_q, state_d;
  logic       rd_valid_q, rd_valid_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       forced;
  logic       expired;
  logic       rd_fire;

  assign forced  = (state_q == ARB_HOST_FORCED);
  assign p_stall = forced & h_req;

  always_comb begin
    p_gnt = 1'b0;
    h_gnt = 1'b0;
    if (gwe) begin
      if (forced) begin
        h_gnt = h_req;
      end else begin
        p_gnt = p_req;
        h_gnt = h_req & ~p_req;
      end
    end
  end

  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (p_gnt) begin
      mem_raddr = p_addr;
      mem_waddr = p_addr;
      mem_wdata = p_wdata;
      mem_we    = p_we;
    end else if (h_gnt) begin
      mem_raddr = h_addr;
      mem_waddr = h_addr;
      mem_wdata = h_wdata;
      mem_we    = h_we;
    end
  end

  lc4_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_wait_ctr (
    .clk     (clk),
    .rst     (rst),
    .en      (gwe),
    .inc     (h_req & ~h_gnt),
    .clr     (h_gnt | ~h_req),
    .expired (expired)
  );

  // A forced gwe cycle always ends with either the host grant or h_req low,
  // so the forced state never lasts more than one gwe cycle.
  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_owner_d = rd_owner_q;
    if (gwe) begin
      if (forced) begin
        state_d = ARB_PROC_PRI;
      end else if (expired) begin
        state_d = ARB_HOST_FORCED;
      end
      rd_valid_d = (p_gnt & ~p_we) | (h_gnt & ~h_we);
      rd_owner_d = h_gnt ? OWN_HOST : OWN_PROC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_PROC_PRI;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_PROC;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // A pending read is dropped if reset arrives in the cycle it would return.
  assign rd_fire  = rd_valid_q & gwe & ~rst;
  assign p_rvalid = rd_fire & (rd_owner_q == OWN_PROC);
  assign h_rvalid = rd_fire & (rd_owner_q == OWN_HOST);
  assign p_rdata  = p_rvalid ? mem_rdata : '0;
  assign h_rdata  = h_rvalid ? mem_rdata : '0;

endmodule

// File: doc/lc4_dmem_arbiter.md
Name: lc4_dmem_arbiter

Overview:
- Shares the single wide data-memory port (`lc4_memory` d-side: `draddr`/`dwaddr`/`din`/`dout`/`dwe`) between the `lc4_processor` and a host/loader port (test or ECC-scrub agent).
- The processor has priority. A bounded-wait counter guarantees host forward progress by stalling the processor.
- Sits between `lc4_processor` and `lc4_memory` in the system top. All state advances only on `gwe`-enabled cycles.

Parameters:
- WORD_SIZE, 256, data width of one memory word.
- ADDR_BITS, 3, data-memory address width (8 words).
- MAX_WAIT, 4, host wait cycles (gwe-qualified) before the host is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- gwe  in  1  global write enable from `lc4_we_gen`; state updates only when 1.
- p_req  in  1  processor requests an access this cycle.
- p_we  in  1  processor access is a write.
- p_addr  in  ADDR_BITS  processor address.
- p_wdata  in  WORD_SIZE  processor write data.
- p_gnt  out  1  processor access accepted this cycle (combinational).
- p_stall  out  1  processor must hold its request; asserted when the host is forced.
- p_rvalid  out  1  processor read data valid (one-cycle pulse).
- p_rdata  out  WORD_SIZE  processor read data.
- h_req, h_we, h_addr, h_wdata  in  1/1/ADDR_BITS/WORD_SIZE  host request, same meaning as the processor fields.
- h_gnt, h_rvalid, h_rdata  out  1/1/WORD_SIZE  host grant, read valid, read data.
- mem_raddr  out  ADDR_BITS  to `draddr`.
- mem_waddr  out  ADDR_BITS  to `dwaddr`.
- mem_wdata  out  WORD_SIZE  to `din`.
- mem_we  out  1  to `dwe`.
- mem_rdata  in  WORD_SIZE  from `dout`.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to PROC_PRI; wait_cnt=0; rd_owner_valid=0.
  - All outputs are 0 in the cycle following reset.
  - A read in flight when rst rises is dropped; no rvalid is issued.
- States: PROC_PRI, HOST_FORCED.
- Grant is combinational, at most one per cycle, and both gnt outputs are 0 when gwe=0:
  - PROC_PRI: p_gnt=p_req. h_gnt=h_req & ~p_req.
  - HOST_FORCED: h_gnt=h_req. p_gnt=0. p_stall=1.
- Memory drive follows the granted requester:
  - Granted requester's addr goes to both mem_raddr and mem_waddr; its wdata goes to mem_wdata.
  - mem_we = gnt & we & gwe.
  - With no grant: addresses are 0 and mem_we=0.
- Read latency: a read granted in gwe-cycle t produces rvalid=1 for exactly one gwe-cycle at t+1.
  - rdata = mem_rdata sampled at that time, routed to the owner captured in a 1-entry owner register.
  - The non-owner's rdata is held at 0.
  - rvalid is held at 0 on cycles with gwe=0.
- Write: completes in the grant cycle. No rvalid.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - On each gwe-cycle with h_req & ~h_gnt: increments, saturating at MAX_WAIT.
  - On h_gnt or ~h_req: clears to 0.
- Transitions:
  - PROC_PRI -> HOST_FORCED when the next wait_cnt value would equal MAX_WAIT.
  - HOST_FORCED -> PROC_PRI after exactly one host grant, or immediately if h_req drops (wait_cnt cleared).
- Simultaneous events:
  - A request arriving in the same cycle as rvalid for a previous read is legal; back-to-back reads are fully pipelined, one per gwe-cycle.
  - In HOST_FORCED with h_req=0, the state returns to PROC_PRI; p_stall deasserts in the same cycle, combinationally from state & h_req.
- Width rules: no arithmetic on data. Addresses pass through unmodified. Out-of-range MAX_WAIT is a generation-time error.

Decomposition:
- Shared package `lc4_mem_pkg`:
  - State enum ARB_PROC_PRI=1'b0, ARB_HOST_FORCED=1'b1.
  - Owner encoding OWN_PROC=0, OWN_HOST=1.
  - WORD_SIZE/ADDR_BITS default constants shared with `lc4_memory` and `lc4_processor`.
- One natural sub-module, `lc4_arb_wait_ctr`: saturating gwe-qualified counter with clear, outputs `expired`.

Test Plan:
- Reset mid-read: proc read addr 3, assert rst in the next cycle -> p_rvalid stays 0; all outputs 0 after reset.
- Proc only: write addr 2 = 0xA5..A5 (256-bit), then read addr 2 -> mem_we=1 in the grant cycle; p_rvalid=1 exactly one gwe-cycle later with p_rdata=0xA5..A5.
- Host only: read addr 7 while p_req=0 -> h_gnt=1 immediately; h_rvalid one gwe-cycle later; p_rdata=0.
- Contention with MAX_WAIT=4: p_req and h_req held high continuously -> the first 4 gwe-cycles grant proc; the 5th cycle has p_stall=1 and h_gnt=1; then proc again (pattern repeats: 4 proc grants, 1 host grant).
- gwe gating: gwe toggled 1-of-4 cycles with both requesting -> grants, mem_we, rvalid and wait_cnt change only on gwe=1 cycles; forced host grant occurs on the 5th gwe cycle, not the 5th clk.
- Back-to-back: proc reads addr 0,1,2 on consecutive gwe-cycles -> three consecutive p_rvalid pulses with data from addrs 0,1,2 in order.
